// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: funct3 codes,
// writeback select encodings and memory-stage bundles.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } buf_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        exc;
  } mem_wb_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (funct3[1:0] == 2'b01): bad = addr[0];
      (funct3[1:0] == 2'b10): bad = (addr != 2'b00);
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data extraction: picks the low byte/half
// of the read word and sign- or zero-extends it.
import riscv_pkg::*;

module load_extend (
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        illegal
);

  // Extend by funct3; 011/110/111 have no meaning.
  always_comb begin
    data    = word;
    illegal = 1'b0;
    unique case (1'b1)
      (funct3 == F3_LB):
        data = {{24{word[7]}}, word[7:0]};
      (funct3 == F3_LBU):
        data = {24'd0, word[7:0]};
      (funct3 == F3_LH):
        data = {{16{word[15]}}, word[15:0]};
      (funct3 == F3_LHU):
        data = {16'd0, word[15:0]};
      (funct3 == F3_LW):
        data = word;
      default: begin
        data    = 32'd0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives dmem, formats load
// results and buffers them in a two-entry skid buffer.
import riscv_pkg::*;

module mem_stage #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rs2_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic [1:0]  in_wb_sel,
  output logic [31:0] dmem_address,
  output logic        dmem_read_write,
  output logic [31:0] dmem_data_in,
  output logic [1:0]  dmem_access_size,
  input  logic [31:0] dmem_data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_wb_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_exc
);

  buf_state_t state;
  buf_state_t state_nx;
  mem_wb_t    main_q;
  mem_wb_t    skid_q;
  mem_wb_t    entry;

  logic [31:0] ld_data;
  logic        ld_illegal;
  logic        is_mem;
  logic        align_bad;
  logic        exc;
  logic        accept;
  logic        load_new;
  logic        load_skid;
  logic        skid_load;

  load_extend u_ext (
    .funct3  (in_funct3),
    .word    (dmem_data_out),
    .data    (ld_data),
    .illegal (ld_illegal)
  );

  assign dmem_address     = in_alu_result;
  assign dmem_data_in     = in_rs2_data;
  assign dmem_access_size = in_funct3[1:0];

  assign is_mem    = in_mem_read | in_mem_write;
  assign align_bad = CHECK_ALIGN &&
    misaligned(in_funct3, in_alu_result[1:0]);
  assign exc       = is_mem && (ld_illegal || align_bad);

  // in_ready is a decode of the state register, so
  // writeback stalls never reach upstream in one cycle.
  assign in_ready = (state != SKID);
  assign accept   = reset_n && in_valid && in_ready && !flush;

  assign dmem_read_write = accept && in_mem_write && !exc;

  // Format the writeback entry at accept time.
  always_comb begin
    entry.pc        = in_pc;
    entry.rd        = in_rd;
    entry.reg_write = in_reg_write && !exc;
    entry.exc       = exc;
    entry.wb_data   = in_alu_result;
    unique case (1'b1)
      (in_wb_sel == WB_MEM): entry.wb_data = ld_data;
      (in_wb_sel == WB_PC4): entry.wb_data = in_pc + 32'd4;
      default:               entry.wb_data = in_alu_result;
    endcase
  end

  // Buffer next-state and register load enables.
  always_comb begin
    state_nx  = state;
    load_new  = 1'b0;
    load_skid = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            load_new = 1'b1;
            state_nx = FULL;
          end
        end
        FULL: begin
          if (accept && out_ready) begin
            load_new = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nx  = SKID;
          end else if (out_ready) begin
            state_nx = EMPTY;
          end
        end
        SKID: begin
          if (out_ready) begin
            load_skid = 1'b1;
            state_nx  = FULL;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nx;
  end

  // Main and skid entry registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_new)  main_q <= entry;
      if (load_skid) main_q <= skid_q;
      if (skid_load) skid_q <= entry;
    end
  end

  assign out_valid     = (state != EMPTY);
  assign out_pc        = main_q.pc;
  assign out_wb_data   = main_q.wb_data;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_exc       = main_q.exc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-array
// data memory model and immediate-assertion checks.
import riscv_pkg::*;

module tb_mem_stage;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic [31:0] in_rs2_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] dmem_address;
  logic        dmem_read_write;
  logic [31:0] dmem_data_in;
  logic [1:0]  dmem_access_size;
  logic [31:0] dmem_data_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_exc;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int p0;

  logic [7:0] mem [0:4095];

  mem_stage dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_pc            (in_pc),
    .in_alu_result    (in_alu_result),
    .in_rs2_data      (in_rs2_data),
    .in_funct3        (in_funct3),
    .in_mem_read      (in_mem_read),
    .in_mem_write     (in_mem_write),
    .in_rd            (in_rd),
    .in_reg_write     (in_reg_write),
    .in_wb_sel        (in_wb_sel),
    .dmem_address     (dmem_address),
    .dmem_read_write  (dmem_read_write),
    .dmem_data_in     (dmem_data_in),
    .dmem_access_size (dmem_access_size),
    .dmem_data_out    (dmem_data_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_wb_data      (out_wb_data),
    .out_rd           (out_rd),
    .out_reg_write    (out_reg_write),
    .out_exc          (out_exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [11:0] i;
    i = a[11:0];
    return {mem[i+12'd3], mem[i+12'd2], mem[i+12'd1], mem[i]};
  endfunction

  assign dmem_data_out = word_at(dmem_address);

  always @(posedge clock) begin
    if (dmem_read_write) begin
      mem[dmem_address[11:0]] <= dmem_data_in[7:0];
      if (dmem_access_size != 2'b00)
        mem[dmem_address[11:0] + 12'd1] <= dmem_data_in[15:8];
      if (dmem_access_size == 2'b10) begin
        mem[dmem_address[11:0] + 12'd2] <= dmem_data_in[23:16];
        mem[dmem_address[11:0] + 12'd3] <= dmem_data_in[31:24];
      end
    end
  end

  always @(negedge clock) if (dmem_read_write) pulses++;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(
    input logic        v,
    input logic [31:0] pc,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic        mr,
    input logic        mw,
    input logic        rw,
    input logic [1:0]  ws
  );
    in_valid      = v;
    in_pc         = pc;
    in_alu_result = a;
    in_rs2_data   = d;
    in_funct3     = f3;
    in_rd         = rd;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_reg_write  = rw;
    in_wb_sel     = ws;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, WB_ALU);
  endtask

  task automatic ld(
    input logic [31:0] pc,
    input logic [31:0] a,
    input logic [2:0]  f3,
    input logic [4:0]  rd
  );
    drv(1, pc, a, 0, f3, rd, 1, 0, 1, WB_MEM);
  endtask

  task automatic st(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [2:0]  f3
  );
    drv(1, 32'h2000, a, d, f3, 0, 0, 1, 0, WB_ALU);
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_wb", out_wb_data, 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_rw", 32'(out_reg_write), 0);
    chk("rst_exc", 32'(out_exc), 0);
    chk("rst_dmem_rw", 32'(dmem_read_write), 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    out_ready = 1'b1;
    st(32'h100, 32'hDEADBEEF, F3_SW);
    #1;
    chk("sw_pulse", 32'(dmem_read_write), 1);
    tick();
    chk("sw_mem", word_at(32'h100), 32'hDEADBEEF);
    chk("sw_valid", 32'(out_valid), 1);
    chk("sw_rw", 32'(out_reg_write), 0);

    ld(32'h1004, 32'h100, F3_LW, 5);
    tick();
    chk("lw_data", out_wb_data, 32'hDEADBEEF);
    chk("lw_rd", 32'(out_rd), 5);
    chk("lw_rw", 32'(out_reg_write), 1);
    chk("lw_pc", out_pc, 32'h1004);

    ld(32'h1008, 32'h103, F3_LB, 6);
    tick();
    chk("lb", out_wb_data, 32'hFFFFFFDE);
    ld(32'h100C, 32'h103, F3_LBU, 6);
    tick();
    chk("lbu", out_wb_data, 32'h000000DE);
    ld(32'h1010, 32'h102, F3_LH, 6);
    tick();
    chk("lh", out_wb_data, 32'hFFFFDEAD);
    ld(32'h1014, 32'h102, F3_LHU, 6);
    tick();
    chk("lhu", out_wb_data, 32'h0000DEAD);
    chk("lhu_exc", 32'(out_exc), 0);

    drv(1, 32'h1018, 32'h12345678, 0, 3'b011, 9, 0, 0, 1, WB_ALU);
    tick();
    chk("alu_data", out_wb_data, 32'h12345678);
    chk("alu_exc", 32'(out_exc), 0);
    drv(1, 32'hFFFFFFFC, 32'h55, 0, 3'b000, 1, 0, 0, 1, WB_PC4);
    tick();
    chk("pc4_wrap", out_wb_data, 32'h0);

    idle();
    tick();
    chk("drain_valid", 32'(out_valid), 0);

    // Backpressure: A to main, B to skid, C held.
    out_ready = 1'b0;
    ld(32'h3000, 32'h100, F3_LW, 1);
    tick();
    ld(32'h3004, 32'h100, F3_LBU, 2);
    tick();
    chk("bp_skid_ready", 32'(in_ready), 0);
    ld(32'h3008, 32'h100, F3_LHU, 3);
    tick();
    chk("bp_held_ready", 32'(in_ready), 0);
    chk("bp_a_rd", 32'(out_rd), 1);
    chk("bp_a_data", out_wb_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    tick();
    chk("bp_b_rd", 32'(out_rd), 2);
    chk("bp_b_data", out_wb_data, 32'h000000EF);
    chk("bp_ready_back", 32'(in_ready), 1);
    tick();
    chk("bp_c_rd", 32'(out_rd), 3);
    chk("bp_c_data", out_wb_data, 32'h0000BEEF);
    idle();
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // Misaligned and illegal accesses.
    p0 = pulses;
    drv(1, 32'h4000, 32'h101, 32'h1234, F3_SH, 4, 0, 1, 1, WB_ALU);
    #1;
    chk("sh_mis_pulse", 32'(dmem_read_write), 0);
    tick();
    chk("sh_mis_exc", 32'(out_exc), 1);
    chk("sh_mis_rw", 32'(out_reg_write), 0);
    chk("sh_mis_mem", word_at(32'h100), 32'hDEADBEEF);
    chk("sh_mis_cnt", 32'(pulses - p0), 0);
    ld(32'h4004, 32'h102, F3_LW, 4);
    tick();
    chk("lw_mis_exc", 32'(out_exc), 1);
    chk("lw_mis_rw", 32'(out_reg_write), 0);
    ld(32'h4008, 32'h100, 3'b110, 4);
    tick();
    chk("ill_exc", 32'(out_exc), 1);
    chk("ill_rw", 32'(out_reg_write), 0);
    idle();
    tick();

    // Store held at input through a SKID period.
    out_ready = 1'b0;
    ld(32'h5000, 32'h100, F3_LW, 1);
    tick();
    ld(32'h5004, 32'h100, F3_LW, 2);
    tick();
    p0 = pulses;
    st(32'h200, 32'h00000055, F3_SB);
    tick();
    tick();
    chk("skst_ready", 32'(in_ready), 0);
    chk("skst_none", 32'(pulses - p0), 0);
    out_ready = 1'b1;
    tick();
    tick();
    idle();
    chk("skst_once", 32'(pulses - p0), 1);
    chk("skst_mem", 32'(mem[12'h200]), 32'h55);
    tick();

    // Reset while in SKID with a store waiting.
    out_ready = 1'b0;
    ld(32'h6000, 32'h100, F3_LW, 1);
    tick();
    ld(32'h6004, 32'h100, F3_LW, 2);
    tick();
    chk("rs_skid", 32'(in_ready), 0);
    p0 = pulses;
    st(32'h300, 32'h11111111, F3_SW);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_valid", 32'(out_valid), 0);
    chk("rs_ready", 32'(in_ready), 1);
    chk("rs_pulse", 32'(dmem_read_write), 0);
    @(negedge clock);
    idle();
    reset_n = 1'b1;
    tick();
    chk("rs_cnt", 32'(pulses - p0), 0);

    // Flush with a store at the input.
    out_ready = 1'b1;
    ld(32'h7000, 32'h100, F3_LW, 7);
    tick();
    chk("fl_pre", 32'(out_valid), 1);
    p0 = pulses;
    flush = 1'b1;
    st(32'h100, 32'h0, F3_SW);
    #1;
    chk("fl_pulse", 32'(dmem_read_write), 0);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_empty", 32'(out_valid), 0);
    chk("fl_mem", word_at(32'h100), 32'hDEADBEEF);
    chk("fl_cnt", 32'(pulses - p0), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
